// File: rtl/fwd_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand forwarding stage.
// Default geometry, select encoding and the zero-register number.
package fwd_operand_stage_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_REGW  = 5;
   localparam int DEF_NFWD  = 2;
   localparam int DEF_SELW  = 2;

   localparam int REG_ZERO  = 0;
   localparam int SEL_RF    = 0;

   // Source k is reported as select value k+1; 0 is reserved for the RF.
   function automatic int sel_of(input int k);
      return k + 1;
   endfunction

endpackage

// File: rtl/fwd_operand_stage_fwd_select.sv
// Per-channel forwarding picker: youngest matching in-flight result
// wins over older sources and over the register file.
module fwd_select
   import fwd_operand_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REGW  = DEF_REGW,
   parameter int NFWD  = DEF_NFWD,
   parameter int SELW  = DEF_SELW
) (
   input  logic [REGW-1:0]       addr,
   input  logic [NFWD-1:0]       fwd_we,
   input  logic [NFWD-1:0]       fwd_is_load,
   input  logic [NFWD*REGW-1:0]  fwd_rd,
   input  logic [NFWD*WIDTH-1:0] fwd_data,
   input  logic [WIDTH-1:0]      rf_data,
   output logic [WIDTH-1:0]      data,
   output logic [SELW-1:0]       sel,
   output logic                  hit_load
);

   logic [NFWD-1:0] match;
   logic            addr_nz;

   assign addr_nz = (addr != REGW'(REG_ZERO));

   for (genvar k = 0; k < NFWD; k++) begin : g_match
      assign match[k] = fwd_we[k] && addr_nz &&
                        (fwd_rd[k*REGW +: REGW] == addr);
   end

   // Walk oldest to youngest so the lowest index overrides.
   always_comb begin
      data     = rf_data;
      sel      = SELW'(SEL_RF);
      hit_load = 1'b0;
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (match[k]) begin
            data     = fwd_data[k*WIDTH +: WIDTH];
            sel      = SELW'(sel_of(k));
            hit_load = fwd_is_load[k];
         end
      end
   end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand register with NFWD-source forwarding on both channels,
// stall/flush control and a combinational load-use hazard request.
module fwd_operand_stage
   import fwd_operand_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REGW  = DEF_REGW,
   parameter int NFWD  = DEF_NFWD,
   parameter int SELW  = DEF_SELW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [REGW-1:0]       rs_addr,
   input  logic [REGW-1:0]       rt_addr,
   input  logic [WIDTH-1:0]      rf_rs_data,
   input  logic [WIDTH-1:0]      rf_rt_data,
   input  logic [NFWD-1:0]       fwd_we,
   input  logic [NFWD-1:0]       fwd_is_load,
   input  logic [NFWD*REGW-1:0]  fwd_rd,
   input  logic [NFWD*WIDTH-1:0] fwd_data,
   output logic [WIDTH-1:0]      op_a,
   output logic [WIDTH-1:0]      op_b,
   output logic [SELW-1:0]       sel_a,
   output logic [SELW-1:0]       sel_b,
   output logic                  out_valid,
   output logic                  load_use
);

   logic [WIDTH-1:0] data_a, data_b;
   logic [SELW-1:0]  pick_a, pick_b;
   logic             ld_a, ld_b;

   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [SELW-1:0]  sel_a_q, sel_a_d;
   logic [SELW-1:0]  sel_b_q, sel_b_d;
   logic             valid_q, valid_d;

   fwd_select #(
      .WIDTH (WIDTH),
      .REGW  (REGW),
      .NFWD  (NFWD),
      .SELW  (SELW)
   ) u_sel_a (
      .addr        (rs_addr),
      .fwd_we      (fwd_we),
      .fwd_is_load (fwd_is_load),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .rf_data     (rf_rs_data),
      .data        (data_a),
      .sel         (pick_a),
      .hit_load    (ld_a)
   );

   fwd_select #(
      .WIDTH (WIDTH),
      .REGW  (REGW),
      .NFWD  (NFWD),
      .SELW  (SELW)
   ) u_sel_b (
      .addr        (rt_addr),
      .fwd_we      (fwd_we),
      .fwd_is_load (fwd_is_load),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .rf_data     (rf_rt_data),
      .data        (data_b),
      .sel         (pick_b),
      .hit_load    (ld_b)
   );

   // Flush beats stall so a squashed instruction never lingers.
   always_comb begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      valid_d = valid_q;
      if (flush) begin
         op_a_d  = '0;
         op_b_d  = '0;
         sel_a_d = '0;
         sel_b_d = '0;
         valid_d = 1'b0;
      end else if (!stall) begin
         op_a_d  = data_a;
         op_b_d  = data_b;
         sel_a_d = pick_a;
         sel_b_d = pick_b;
         valid_d = in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         valid_q <= 1'b0;
      end else begin
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         valid_q <= valid_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign sel_a     = sel_a_q;
   assign sel_b     = sel_b_q;
   assign out_valid = valid_q;
   assign load_use  = in_valid && (ld_a || ld_b);

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Randomised scoreboard bench for fwd_operand_stage (NFWD=2, WIDTH=32)
// against a first-match reference model.
module tb_fwd_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, stall, flush;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rf_rs_data, rf_rt_data;
   logic [1:0]  fwd_we, fwd_is_load;
   logic [9:0]  fwd_rd;
   logic [63:0] fwd_data;
   logic [31:0] op_a, op_b;
   logic [1:0]  sel_a, sel_b;
   logic        out_valid, load_use;

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic        lu;
   } exp_t;

   exp_t expq[$];
   exp_t cur;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   fwd_operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .stall       (stall),
      .flush       (flush),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rf_rs_data  (rf_rs_data),
      .rf_rt_data  (rf_rt_data),
      .fwd_we      (fwd_we),
      .fwd_is_load (fwd_is_load),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .op_a        (op_a),
      .op_b        (op_b),
      .sel_a       (sel_a),
      .sel_b       (sel_b),
      .out_valid   (out_valid),
      .load_use    (load_use)
   );

   // Reference: first (youngest) source writing a nonzero addr wins.
   function automatic void pick(
      input  logic [4:0]  addr,
      input  logic [1:0]  we,
      input  logic [1:0]  ld,
      input  logic [4:0]  r0,
      input  logic [4:0]  r1,
      input  logic [31:0] d0,
      input  logic [31:0] d1,
      input  logic [31:0] rf,
      output logic [31:0] data,
      output logic [1:0]  sel,
      output logic        isld
   );
      logic [4:0]  rd[2];
      logic [31:0] d[2];
      rd[0] = r0; rd[1] = r1;
      d[0]  = d0; d[1]  = d1;
      data = rf; sel = 2'd0; isld = 1'b0;
      if (addr != 5'd0) begin
         for (int k = 0; k < 2; k++) begin
            if (we[k] && rd[k] == addr) begin
               data = d[k];
               sel  = 2'(k + 1);
               isld = ld[k];
               break;
            end
         end
      end
   endfunction

   task automatic drive(
      input logic        v,
      input logic        st,
      input logic        fl,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [31:0] rfs,
      input logic [31:0] rft,
      input logic [1:0]  we,
      input logic [1:0]  ld,
      input logic [4:0]  r0,
      input logic [4:0]  r1,
      input logic [31:0] d0,
      input logic [31:0] d1
   );
      exp_t        e;
      logic [31:0] da, db;
      logic [1:0]  sa, sb;
      logic        la, lb;
      @(negedge clk);
      in_valid    = v;
      stall       = st;
      flush       = fl;
      rs_addr     = rs;
      rt_addr     = rt;
      rf_rs_data  = rfs;
      rf_rt_data  = rft;
      fwd_we      = we;
      fwd_is_load = ld;
      fwd_rd      = {r1, r0};
      fwd_data    = {d1, d0};
      pick(rs, we, ld, r0, r1, d0, d1, rfs, da, sa, la);
      pick(rt, we, ld, r0, r1, d0, d1, rft, db, sb, lb);
      if (fl) begin
         cur.v = 1'b0; cur.a = '0; cur.b = '0;
         cur.sa = '0; cur.sb = '0;
      end else if (!st) begin
         cur.v = v; cur.a = da; cur.b = db;
         cur.sa = sa; cur.sb = sb;
      end
      e = cur;
      e.lu = v && (la || lb);
      expq.push_back(e);
   endtask

   task automatic check_reset(input string tag);
      vectors++;
      if (op_a !== 0 || op_b !== 0 || sel_a !== 0 ||
          sel_b !== 0 || out_valid !== 0) begin
         miscompares++;
         $display("FAIL %s: got a=%h b=%h sa=%0d sb=%0d v=%b required all 0",
                  tag, op_a, op_b, sel_a, sel_b, out_valid);
      end
   endtask

   // Monitor: compare registered outputs just after each capturing edge.
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            bad = 1'b0;
            vectors++;
            if (out_valid !== e.v) begin
               bad = 1'b1;
               $display("FAIL out_valid: got %b required %b", out_valid, e.v);
            end
            if (op_a !== e.a || sel_a !== e.sa) begin
               bad = 1'b1;
               $display("FAIL chan_a: got %h/%0d required %h/%0d",
                        op_a, sel_a, e.a, e.sa);
            end
            if (op_b !== e.b || sel_b !== e.sb) begin
               bad = 1'b1;
               $display("FAIL chan_b: got %h/%0d required %h/%0d",
                        op_b, sel_b, e.b, e.sb);
            end
            if (load_use !== e.lu) begin
               bad = 1'b1;
               $display("FAIL load_use: got %b required %b", load_use, e.lu);
            end
            if (bad) miscompares++;
         end
      end
   end

   initial begin
      cur = '{v: 1'b0, a: '0, b: '0, sa: '0, sb: '0, lu: 1'b0};
      rst_n = 1'b0;
      in_valid = 0; stall = 0; flush = 1;
      rs_addr = 0; rt_addr = 0; rf_rs_data = 0; rf_rt_data = 0;
      fwd_we = 0; fwd_is_load = 0; fwd_rd = 0; fwd_data = 0;
      @(negedge clk);
      #1 check_reset("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // Two sources hit rs: youngest wins.
      drive(1, 0, 0, 5, 0, 32'h1, 32'h2, 2'b11, 2'b00,
            5, 5, 32'hAAAA, 32'hBBBB);
      // $0 is never forwarded.
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'b01, 2'b00,
            0, 0, 32'h1234, 32'h0);
      // Only the older source matches rt, then an rd mismatch.
      drive(1, 0, 0, 1, 7, 32'h9, 32'h11, 2'b10, 2'b00,
            4, 7, 32'h3, 32'hC0DE);
      drive(1, 0, 0, 1, 7, 32'h9, 32'h11, 2'b10, 2'b00,
            4, 6, 32'h3, 32'hC0DE);
      // Load-use, one stall cycle, then the load result arrives from source 1.
      drive(1, 0, 0, 3, 0, 32'h7, 32'h8, 2'b01, 2'b01,
            3, 0, 32'hDEAD, 32'h0);
      drive(1, 1, 0, 3, 0, 32'h7, 32'h8, 2'b01, 2'b01,
            3, 0, 32'hDEAD, 32'h0);
      drive(1, 0, 0, 3, 0, 32'h7, 32'h8, 2'b10, 2'b00,
            0, 3, 32'h0, 32'h5555);
      // Shadowed older load gives no hazard.
      drive(1, 0, 0, 3, 0, 32'h7, 32'h8, 2'b11, 2'b10,
            3, 3, 32'h6666, 32'h7777);
      // Stall-only holds; stall with flush squashes.
      drive(0, 1, 0, 9, 9, 32'h1, 32'h1, 2'b00, 2'b00,
            0, 0, 32'h0, 32'h0);
      drive(1, 1, 1, 3, 3, 32'h1, 32'h1, 2'b11, 2'b11,
            3, 3, 32'h1, 32'h1);

      // Async reset mid-run while out_valid is high.
      drive(1, 0, 0, 2, 2, 32'hF00D, 32'hBEEF, 2'b00, 2'b00,
            0, 0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      flush = 1'b1;
      #1 check_reset("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cur.v = 1'b0; cur.a = '0; cur.b = '0; cur.sa = '0; cur.sb = '0;

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom, $urandom,
               2'($urandom), 2'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom, $urandom);
      end

      repeat (3) @(posedge clk);
      #2;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected outputs never checked, required 0",
                  expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
